// File: rtl/dk_trigger_sequencer_if.sv
// Valid/ready stream carrying captured audio samples out of the trigger sequencer.
interface dk_trigger_sequencer_if #(
   parameter int SAMPLE_W = 16
);
   logic [SAMPLE_W-1:0] out_data;
   logic                out_valid;
   logic                out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/dk_trigger_sequencer.sv
// Multi-channel trigger sequencer for discrete-sound blocks: sample-tick divider,
// per-channel high/low/repeat trigger FSMs and a valid/ready sample capture stage.
module dk_trigger_sequencer #(
   parameter int CLOCK_RATE  = 192000,
   parameter int SAMPLE_RATE = 96000,
   parameter int CHANNELS    = 4,
   parameter int CNT_W       = 16,
   parameter int REP_W       = 8,
   parameter int SAMPLE_W    = 16
) (
   input  logic                      clk,
   input  logic                      I_RST,
   input  logic [CHANNELS-1:0]       start,
   input  logic                      stop,
   input  logic [CHANNELS*CNT_W-1:0] high_len,
   input  logic [CHANNELS*CNT_W-1:0] low_len,
   input  logic [CHANNELS*REP_W-1:0] repeats,
   input  logic [CHANNELS-1:0]       active_low,
   input  logic [SAMPLE_W-1:0]       sample_in,
   output logic                      audio_clk_en,
   output logic [CHANNELS-1:0]       trig,
   output logic [CHANNELS-1:0]       busy,
   output logic [CHANNELS-1:0]       done,
   dk_trigger_sequencer_if.master    cap,
   output logic                      overflow
);
   localparam int DIV   = CLOCK_RATE / SAMPLE_RATE;
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   generate
      if (DIV < 2) begin : g_bad_div
         $error("dk_trigger_sequencer: CLOCK_RATE/SAMPLE_RATE must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

   logic [DIV_W-1:0] divider;

   state_t           state     [CHANNELS];
   state_t           state_nxt [CHANNELS];
   logic [CNT_W-1:0] cnt       [CHANNELS];
   logic [CNT_W-1:0] cnt_nxt   [CHANNELS];
   logic [REP_W-1:0] rem       [CHANNELS];
   logic [REP_W-1:0] rem_nxt   [CHANNELS];
   logic [CNT_W-1:0] high_r    [CHANNELS];
   logic [CNT_W-1:0] low_r     [CHANNELS];
   logic [REP_W-1:0] rep_r     [CHANNELS];
   logic [CHANNELS-1:0] end_rep;

   // Strobe is registered, so it rises on the DIV-th edge after reset release.
   always_ff @(posedge clk) begin
      if (I_RST) begin
         divider      <= '0;
         audio_clk_en <= 1'b0;
      end else begin
         audio_clk_en <= (divider == DIV_LAST);
         divider      <= (divider == DIV_LAST) ? '0 : divider + 1'b1;
      end
   end

   function automatic logic [CNT_W-1:0] high_load(input logic [CNT_W-1:0] len);
      return (len == '0) ? CNT_W'(1) : len;
   endfunction

   always_comb begin
      end_rep = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         state_nxt[c] = state[c];
         cnt_nxt[c]   = cnt[c];
         rem_nxt[c]   = rem[c];
         done[c]      = 1'b0;
         busy[c]      = (state[c] != IDLE);
         if (stop) begin
            state_nxt[c] = IDLE;
         end else if (start[c]) begin
            state_nxt[c] = ARMED;
         end else if (audio_clk_en) begin
            case (state[c])
               ARMED: begin
                  state_nxt[c] = HIGH;
                  cnt_nxt[c]   = high_load(high_r[c]);
                  rem_nxt[c]   = rep_r[c];
               end
               HIGH: begin
                  if (cnt[c] > CNT_W'(1)) begin
                     cnt_nxt[c] = cnt[c] - 1'b1;
                  end else if (low_r[c] != '0) begin
                     state_nxt[c] = LOW;
                     cnt_nxt[c]   = low_r[c];
                  end else begin
                     end_rep[c] = 1'b1;
                  end
               end
               LOW: begin
                  if (cnt[c] > CNT_W'(1)) cnt_nxt[c] = cnt[c] - 1'b1;
                  else                    end_rep[c] = 1'b1;
               end
               default: ;
            endcase
            // A zero repeat field means free-running until stop.
            if (end_rep[c]) begin
               if (rep_r[c] != '0 && rem[c] == REP_W'(1)) begin
                  state_nxt[c] = IDLE;
                  done[c]      = 1'b1;
               end else begin
                  state_nxt[c] = HIGH;
                  cnt_nxt[c]   = high_load(high_r[c]);
                  if (rep_r[c] != '0) rem_nxt[c] = rem[c] - 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (I_RST) begin
            state[c]  <= IDLE;
            cnt[c]    <= '0;
            rem[c]    <= '0;
            high_r[c] <= '0;
            low_r[c]  <= '0;
            rep_r[c]  <= '0;
            trig[c]   <= active_low[c];
         end else begin
            state[c] <= state_nxt[c];
            cnt[c]   <= cnt_nxt[c];
            rem[c]   <= rem_nxt[c];
            trig[c]  <= (state_nxt[c] == HIGH) ^ active_low[c];
            if (start[c] && !stop) begin
               high_r[c] <= high_len[c*CNT_W +: CNT_W];
               low_r[c]  <= low_len[c*CNT_W +: CNT_W];
               rep_r[c]  <= repeats[c*REP_W +: REP_W];
            end
         end
      end
   end

   // A drop in the same cycle as a start still leaves overflow set.
   always_ff @(posedge clk) begin
      if (I_RST) begin
         cap.out_data  <= '0;
         cap.out_valid <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         if (|start) overflow <= 1'b0;
         if (audio_clk_en) begin
            if (!cap.out_valid || cap.out_ready) begin
               cap.out_data  <= sample_in;
               cap.out_valid <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (cap.out_valid && cap.out_ready) begin
            cap.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_dk_trigger_sequencer.sv
// Directed bench for dk_trigger_sequencer with DIV=4; t counts rising edges since reset release.
module tb_dk_trigger_sequencer;
   localparam int CH = 4;

   logic          clk;
   logic          I_RST;
   logic [CH-1:0] start;
   logic          stop;
   logic [63:0]   high_len;
   logic [63:0]   low_len;
   logic [31:0]   repeats;
   logic [CH-1:0] active_low;
   logic [15:0]   sample_in;
   logic          audio_clk_en;
   logic [CH-1:0] trig;
   logic [CH-1:0] busy;
   logic [CH-1:0] done;
   logic          overflow;

   logic [CH-1:0] exp_trig;
   logic [CH-1:0] exp_busy;
   logic [CH-1:0] exp_done;

   int checks;
   int errors;
   int t;

   dk_trigger_sequencer_if #(.SAMPLE_W(16)) cap_if ();

   dk_trigger_sequencer #(
      .CLOCK_RATE (192000),
      .SAMPLE_RATE(48000),
      .CHANNELS   (CH),
      .CNT_W      (16),
      .REP_W      (8),
      .SAMPLE_W   (16)
   ) dut (
      .clk         (clk),
      .I_RST       (I_RST),
      .start       (start),
      .stop        (stop),
      .high_len    (high_len),
      .low_len     (low_len),
      .repeats     (repeats),
      .active_low  (active_low),
      .sample_in   (sample_in),
      .audio_clk_en(audio_clk_en),
      .trig        (trig),
      .busy        (busy),
      .done        (done),
      .cap         (cap_if.master),
      .overflow    (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s t=%0d observed %0h expected %0h", tag, t, observed, expected);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic check_channels();
      check_output("trig", {28'd0, trig}, {28'd0, exp_trig});
      check_output("busy", {28'd0, busy}, {28'd0, exp_busy});
      check_output("done", {28'd0, done}, {28'd0, exp_done});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      t = 0;
      I_RST = 1'b1;
      start = '0;
      stop = 1'b0;
      high_len = '0;
      low_len = '0;
      repeats = '0;
      active_low = 4'b0010;
      sample_in = 16'h1234;
      cap_if.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check_output("rst_clk_en", {31'd0, audio_clk_en}, 32'd0);
      check_output("rst_trig", {28'd0, trig}, 32'h2);
      check_output("rst_busy", {28'd0, busy}, 32'd0);
      check_output("rst_done", {28'd0, done}, 32'd0);
      check_output("rst_valid", {31'd0, cap_if.out_valid}, 32'd0);
      check_output("rst_data", {16'd0, cap_if.out_data}, 32'd0);
      check_output("rst_overflow", {31'd0, overflow}, 32'd0);
      I_RST = 1'b0;
      t = 0;

      // Divider: strobe on edges 4, 8, ... and capture one edge later
      repeat (20) begin
         next_cycle();
         check_output("clk_en", {31'd0, audio_clk_en}, (t % 4 == 0) ? 32'd1 : 32'd0);
         check_output("cap_valid", {31'd0, cap_if.out_valid}, (t > 1 && t % 4 == 1) ? 32'd1 : 32'd0);
         if (t == 5) check_output("cap_data", {16'd0, cap_if.out_data}, 32'h1234);
      end

      // ch0: high 1, low 6, 8 repeats; ch1 active-low: high 2, low 3, endless
      next_cycle();
      high_len = {16'd0, 16'd0, 16'd2, 16'd1};
      low_len  = {16'd0, 16'd0, 16'd3, 16'd6};
      repeats  = {8'd0, 8'd0, 8'd0, 8'd8};
      start = 4'b0011;
      while (t < 249) begin
         next_cycle();
         start = '0;
         exp_trig = 4'b0010;
         exp_busy = (t <= 248) ? 4'b0011 : 4'b0010;
         exp_done = (t == 248) ? 4'b0001 : 4'b0000;
         if (t >= 25 && t <= 248 && ((t - 25) % 28) < 4) exp_trig[0] = 1'b1;
         if (t >= 25 && ((t - 25) % 20) < 8) exp_trig[1] = 1'b0;
         check_channels();
      end
      stop = 1'b1;
      next_cycle();
      stop = 1'b0;
      check_output("stop_trig", {28'd0, trig}, 32'h2);
      check_output("stop_busy", {28'd0, busy}, 32'd0);
      check_output("stop_done", {28'd0, done}, 32'd0);

      // ch2: high 0 acts as 1, low 0 gives continuous high for 3 ticks
      high_len = '0;
      low_len  = '0;
      repeats  = {8'd0, 8'd3, 8'd0, 8'd0};
      start = 4'b0100;
      while (t < 265) begin
         next_cycle();
         start = '0;
         exp_trig = (t >= 253 && t <= 264) ? 4'b0110 : 4'b0010;
         exp_busy = (t <= 264) ? 4'b0100 : 4'b0000;
         exp_done = (t == 264) ? 4'b0100 : 4'b0000;
         check_channels();
      end

      // ch0 restarted mid-HIGH with a 5-tick high phase
      high_len = {16'd0, 16'd0, 16'd0, 16'd3};
      low_len  = {16'd0, 16'd0, 16'd0, 16'd2};
      repeats  = {8'd0, 8'd0, 8'd0, 8'd2};
      start = 4'b0001;
      while (t < 297) begin
         next_cycle();
         start = '0;
         exp_trig = 4'b0010;
         if ((t >= 269 && t <= 274) || (t >= 277 && t <= 296)) exp_trig[0] = 1'b1;
         exp_busy = 4'b0001;
         exp_done = 4'b0000;
         check_channels();
         if (t == 274) begin
            high_len = {16'd0, 16'd0, 16'd0, 16'd5};
            start = 4'b0001;
         end
      end

      // start and stop together: stop wins
      high_len = {16'd0, 16'd2, 16'd0, 16'd0};
      repeats  = {8'd0, 8'd1, 8'd0, 8'd0};
      start = 4'b0100;
      stop = 1'b1;
      next_cycle();
      start = '0;
      stop = 1'b0;
      check_output("ss_busy", {28'd0, busy}, 32'd0);
      check_output("ss_trig", {28'd0, trig}, 32'h2);

      // Capture with the sink stalled for three ticks
      cap_if.out_ready = 1'b0;
      sample_in = 16'h0A01;
      while (t < 312) begin
         next_cycle();
         if (t == 301) begin
            check_output("ss_busy_late", {28'd0, busy}, 32'd0);
            check_output("stall_valid", {31'd0, cap_if.out_valid}, 32'd1);
            check_output("stall_data1", {16'd0, cap_if.out_data}, 32'h0A01);
            check_output("stall_ovf1", {31'd0, overflow}, 32'd0);
            sample_in = 16'h0A02;
         end
         if (t == 305) begin
            check_output("stall_data2", {16'd0, cap_if.out_data}, 32'h0A01);
            check_output("stall_ovf2", {31'd0, overflow}, 32'd1);
            sample_in = 16'h0A03;
         end
         if (t == 309) begin
            check_output("stall_data3", {16'd0, cap_if.out_data}, 32'h0A01);
            check_output("stall_ovf3", {31'd0, overflow}, 32'd1);
            check_output("stall_valid3", {31'd0, cap_if.out_valid}, 32'd1);
         end
      end
      check_output("tick_312", {31'd0, audio_clk_en}, 32'd1);
      cap_if.out_ready = 1'b1;
      sample_in = 16'h0A04;
      next_cycle();
      check_output("resume_valid", {31'd0, cap_if.out_valid}, 32'd1);
      check_output("resume_data", {16'd0, cap_if.out_data}, 32'h0A04);
      check_output("resume_ovf", {31'd0, overflow}, 32'd1);
      next_cycle();
      check_output("drain_valid", {31'd0, cap_if.out_valid}, 32'd0);
      check_output("drain_ovf", {31'd0, overflow}, 32'd1);

      high_len = {16'd1, 16'd0, 16'd0, 16'd0};
      low_len  = {16'd1, 16'd0, 16'd0, 16'd0};
      repeats  = {8'd1, 8'd0, 8'd0, 8'd0};
      start = 4'b1000;
      next_cycle();
      start = '0;
      check_output("clr_ovf", {31'd0, overflow}, 32'd0);
      check_output("ch3_busy", {28'd0, busy}, 32'h8);
      stop = 1'b1;
      next_cycle();
      stop = 1'b0;
      check_output("final_busy", {28'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
